// File: rtl/core_mmio_initiator.sv
// core_mmio_initiator: single-outstanding MMIO bus initiator.
// Takes 64-bit load/store requests from the core and runs each one as a
// single access on the mmio_* bus. Misaligned or out-of-region addresses
// are answered locally with an error and never reach the bus.
// Optional feature: define CORE_MMIO_TIMEOUT_EN to abandon a request whose
// grant does not arrive within TIMEOUT_CYCLES cycles.
module core_mmio_initiator #(
  parameter logic [63:0] MMIO_BASE_ADDR = 64'h0000_0000_0000_1000,
  parameter logic [63:0] MMIO_BASE_MASK = 64'h0000_0000_0000_1FFF,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        cpu_req,
  input  logic        cpu_wen,
  input  logic [63:0] cpu_addr,
  input  logic [63:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_rsp_valid,
  output logic [63:0] cpu_rdata,
  output logic        cpu_error,
  output logic        mmio_req,
  output logic        mmio_wen,
  output logic [63:0] mmio_addr,
  output logic [63:0] mmio_wdata,
  input  logic        mmio_gnt,
  input  logic [63:0] mmio_rdata,
  input  logic        mmio_error
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP
  } state_e;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        wen_q, wen_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [63:0] rdata_q, rdata_d;
  logic        error_q, error_d;
  logic        addr_ok;

`ifdef CORE_MMIO_TIMEOUT_EN
  localparam logic [8:0] TMO_LIMIT = 9'(TIMEOUT_CYCLES);
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
`endif

  // Request may go on the bus only if doubleword-aligned and inside the region.
  always_comb begin
    addr_ok = (cpu_addr[2:0] == 3'b000) &&
              ((cpu_addr & ~MMIO_BASE_MASK) == (MMIO_BASE_ADDR & ~MMIO_BASE_MASK));
  end

  // Next-state and registered-output logic for IDLE -> REQ -> RSP.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    wen_d       = wen_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    error_d     = error_q;
`ifdef CORE_MMIO_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (addr_ok) begin
            req_d   = 1'b1;
            wen_d   = cpu_wen;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
            state_d = REQ;
`ifdef CORE_MMIO_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end else begin
            rsp_valid_d = 1'b1;
            error_d     = 1'b1;
            rdata_d     = '0;
          end
        end
      end
      REQ: begin
        if (mmio_gnt) begin
          req_d   = 1'b0;
          state_d = RSP;
        end
`ifdef CORE_MMIO_TIMEOUT_EN
        // The limit counts this cycle too, so the bus sees exactly
        // TIMEOUT_CYCLES ungranted request cycles before giving up.
        else if (({1'b0, tmo_cnt_q} + 9'd1) == TMO_LIMIT) begin
          req_d       = 1'b0;
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          error_d     = 1'b1;
          rdata_d     = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
`endif
      end
      RSP: begin
        rdata_d     = mmio_rdata;
        error_d     = mmio_error;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      error_q     <= 1'b0;
`ifdef CORE_MMIO_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      error_q     <= error_d;
`ifdef CORE_MMIO_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign cpu_ready     = (state_q == IDLE);
  assign cpu_rsp_valid = rsp_valid_q;
  assign cpu_rdata     = rdata_q;
  assign cpu_error     = error_q;
  assign mmio_req      = req_q;
  assign mmio_wen      = wen_q;
  assign mmio_addr     = addr_q;
  assign mmio_wdata    = wdata_q;

endmodule

// File: tb/tb_core_mmio_initiator.sv
// Scoreboard bench for core_mmio_initiator: stimulus pushes the expected
// response, a monitor pops and compares on every cpu_rsp_valid pulse.
module tb_core_mmio_initiator;

  logic        g_clk;
  logic        g_resetn;
  logic        cpu_req;
  logic        cpu_wen;
  logic [63:0] cpu_addr;
  logic [63:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_rsp_valid;
  logic [63:0] cpu_rdata;
  logic        cpu_error;
  logic        mmio_req;
  logic        mmio_wen;
  logic [63:0] mmio_addr;
  logic [63:0] mmio_wdata;
  logic        mmio_gnt;
  logic [63:0] mmio_rdata;
  logic        mmio_error;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  core_mmio_initiator #(
    .MMIO_BASE_ADDR(64'h0000_0000_0000_1000),
    .MMIO_BASE_MASK(64'h0000_0000_0000_1FFF),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .g_clk        (g_clk),
    .g_resetn     (g_resetn),
    .cpu_req      (cpu_req),
    .cpu_wen      (cpu_wen),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_ready    (cpu_ready),
    .cpu_rsp_valid(cpu_rsp_valid),
    .cpu_rdata    (cpu_rdata),
    .cpu_error    (cpu_error),
    .mmio_req     (mmio_req),
    .mmio_wen     (mmio_wen),
    .mmio_addr    (mmio_addr),
    .mmio_wdata   (mmio_wdata),
    .mmio_gnt     (mmio_gnt),
    .mmio_rdata   (mmio_rdata),
    .mmio_error   (mmio_error)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  // Responder: data/error registered the cycle after a granted request.
  // 0x1000 returns 0x123; 0x1010 returns an error; others return addr ^ A5A5<<48.
  // Outside a granted request it drives garbage with error set.
  always @(posedge g_clk) begin
    if (mmio_req && mmio_gnt) begin
      mmio_rdata <= (mmio_addr == 64'h1000) ? 64'h123
                                             : (mmio_addr ^ 64'hA5A5_0000_0000_0000);
      mmio_error <= (mmio_addr == 64'h1010);
    end else begin
      mmio_rdata <= 64'hBADB_AD00_DEAD_0000;
      mmio_error <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h required %h", nm, act, req);
  endtask

  // Scoreboard monitor.
  always @(negedge g_clk) begin
    if (g_resetn === 1'b1 && cpu_rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_rsp: got rdata %h error %b required no response",
                 cpu_rdata, cpu_error);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_rdata", cpu_rdata, e.rdata);
        chk("rsp_error", {63'd0, cpu_error}, {63'd0, e.err});
      end
    end
  end

  // Present a request from a negedge, wait (bounded) for ready, push the
  // expected response and drop cpu_req just after the accepting edge.
  task automatic send(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                      input bit expect_rsp, input logic [63:0] erd, input logic eerr,
                      output bit acc_with_rsp);
    int n;
    exp_t e;
    @(negedge g_clk);
    cpu_req   = 1'b1;
    cpu_wen   = wen;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    n = 0;
    while (cpu_ready !== 1'b1 && n < 50) begin
      @(negedge g_clk);
      n++;
    end
    acc_with_rsp = 1'b0;
    if (cpu_ready !== 1'b1) begin
      checks++;
      $display("FAIL ready_wait: got cpu_ready %b required 1 within 50 cycles", cpu_ready);
    end else begin
      acc_with_rsp = (cpu_rsp_valid === 1'b1);
      if (expect_rsp) begin
        e.rdata = erd;
        e.err   = eerr;
        exp_q.push_back(e);
      end
      @(posedge g_clk);
    end
    #1;
    cpu_req = 1'b0;
  endtask

  initial begin
    bit acc;
    int cnt;
    g_resetn  = 1'b0;
    cpu_req   = 1'b0;
    cpu_wen   = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    mmio_gnt  = 1'b1;
    repeat (2) @(negedge g_clk);
    chk("rst_mmio_req", {63'd0, mmio_req}, 64'd0);
    chk("rst_rsp_valid", {63'd0, cpu_rsp_valid}, 64'd0);
    chk("rst_mmio_addr", mmio_addr, 64'd0);
    chk("rst_cpu_rdata", cpu_rdata, 64'd0);
    chk("rst_cpu_ready", {63'd0, cpu_ready}, 64'd1);
    g_resetn = 1'b1;

    // Read 0x1000, grant tied high: req one cycle, response at cycle 3.
    send(1'b0, 64'h1000, 64'h0, 1'b1, 64'h123, 1'b0, acc);
    @(negedge g_clk);
    chk("rd_req_c1", {63'd0, mmio_req}, 64'd1);
    chk("rd_addr_c1", mmio_addr, 64'h1000);
    @(negedge g_clk);
    chk("rd_req_c2", {63'd0, mmio_req}, 64'd0);
    chk("rd_rsp_c2", {63'd0, cpu_rsp_valid}, 64'd0);
    @(negedge g_clk);
    chk("rd_rsp_c3", {63'd0, cpu_rsp_valid}, 64'd1);
    repeat (2) @(negedge g_clk);

    // Write 0x1008, grant four cycles late: bus held stable for 5 REQ cycles.
    mmio_gnt = 1'b0;
    send(1'b1, 64'h1008, 64'hDEAD_BEEF, 1'b1, 64'hA5A5_0000_0000_1008, 1'b0, acc);
    for (int i = 0; i < 5; i++) begin
      @(negedge g_clk);
      chk("wr_req_held", {63'd0, mmio_req}, 64'd1);
      chk("wr_wen_held", {63'd0, mmio_wen}, 64'd1);
      chk("wr_addr_held", mmio_addr, 64'h1008);
      chk("wr_wdata_held", mmio_wdata, 64'hDEAD_BEEF);
      if (i == 4) mmio_gnt = 1'b1;
    end
    @(negedge g_clk);
    chk("wr_req_drop", {63'd0, mmio_req}, 64'd0);
    repeat (3) @(negedge g_clk);

    // Illegal addresses: answered locally next cycle, bus untouched.
    send(1'b0, 64'h1004, 64'h0, 1'b1, 64'h0, 1'b1, acc);
    @(negedge g_clk);
    chk("mis_req", {63'd0, mmio_req}, 64'd0);
    chk("mis_rsp", {63'd0, cpu_rsp_valid}, 64'd1);
    send(1'b1, 64'h4000, 64'h55, 1'b1, 64'h0, 1'b1, acc);
    @(negedge g_clk);
    chk("oor_req", {63'd0, mmio_req}, 64'd0);
    chk("oor_rsp", {63'd0, cpu_rsp_valid}, 64'd1);
    repeat (2) @(negedge g_clk);

    // Bus error on read 0x1010.
    send(1'b0, 64'h1010, 64'h0, 1'b1, 64'hA5A5_0000_0000_1010, 1'b1, acc);
    repeat (4) @(negedge g_clk);

    // Back-to-back reads: second accepted alongside the first response.
    send(1'b0, 64'h1000, 64'h0, 1'b1, 64'h123, 1'b0, acc);
    send(1'b0, 64'h1018, 64'h0, 1'b1, 64'hA5A5_0000_0000_1018, 1'b0, acc);
    chk("b2b_accept_with_rsp", {63'd0, acc}, 64'd1);
    repeat (5) @(negedge g_clk);

    // Reset while in REQ: everything clears, no response afterwards.
    mmio_gnt = 1'b0;
    send(1'b0, 64'h1020, 64'h0, 1'b0, 64'h0, 1'b0, acc);
    repeat (2) @(negedge g_clk);
    g_resetn = 1'b0;
    #1;
    chk("mid_rst_req", {63'd0, mmio_req}, 64'd0);
    chk("mid_rst_addr", mmio_addr, 64'd0);
    chk("mid_rst_rdata", cpu_rdata, 64'd0);
    chk("mid_rst_error", {63'd0, cpu_error}, 64'd0);
    @(negedge g_clk);
    g_resetn = 1'b1;
    mmio_gnt = 1'b1;
    repeat (10) @(negedge g_clk);
    chk("post_rst_ready", {63'd0, cpu_ready}, 64'd1);
    chk("post_rst_req", {63'd0, mmio_req}, 64'd0);

    // Grant withheld.
    mmio_gnt = 1'b0;
`ifdef CORE_MMIO_TIMEOUT_EN
    send(1'b0, 64'h1028, 64'h0, 1'b1, 64'h0, 1'b1, acc);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge g_clk);
      if (mmio_req === 1'b1) cnt++;
    end
    chk("tmo_req_cycles", 64'(cnt), 64'd16);
    chk("tmo_ready", {63'd0, cpu_ready}, 64'd1);
    mmio_gnt = 1'b1;
`else
    send(1'b0, 64'h1028, 64'h0, 1'b0, 64'h0, 1'b0, acc);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge g_clk);
      if (mmio_req === 1'b1) cnt++;
    end
    chk("no_tmo_req_cycles", 64'(cnt), 64'd100);
    g_resetn = 1'b0;
    @(negedge g_clk);
    g_resetn = 1'b1;
    mmio_gnt = 1'b1;
`endif
    repeat (5) @(negedge g_clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached with %0d/%0d passed", passed, checks);
    $fatal(1);
  end

endmodule

// File: doc/core_mmio_initiator.md
Name: core_mmio_initiator

Overview:
- Single-outstanding MMIO bus initiator. Drives the mmio_req/wen/addr/wdata/gnt/rdata/error bus that the counter/timer block and other MMIO responders implement.
- Accepts 64-bit load/store requests from the core's memory stage, issues them on the MMIO bus, collects the registered response and returns it to the core.
- Filters misaligned and out-of-region accesses locally, so the bus never sees them.

Parameters:
- MMIO_BASE_ADDR, 64'h0000_0000_0000_1000: base of the MMIO region.
- MMIO_BASE_MASK, 64'h0000_0000_0000_1FFF: address bits decoded by responders. Bits outside the mask must match MMIO_BASE_ADDR.
- TIMEOUT_CYCLES, 16: grant-wait limit in cycles, range 1..255. Used only with the optional feature.

Ports:
- g_clk  in  1  global clock
- g_resetn  in  1  asynchronous active-low reset
- cpu_req  in  1  core request valid
- cpu_wen  in  1  core write enable (1 = store)
- cpu_addr  in  64  core byte address
- cpu_wdata  in  64  core write data
- cpu_ready  out  1  initiator can accept a request this cycle
- cpu_rsp_valid  out  1  one-cycle response pulse
- cpu_rdata  out  64  response read data
- cpu_error  out  1  response error
- mmio_req  out  1  bus request
- mmio_wen  out  1  bus write enable
- mmio_addr  out  64  bus address
- mmio_wdata  out  64  bus write data
- mmio_gnt  in  1  bus grant
- mmio_rdata  in  64  bus read data, valid the cycle after a granted request
- mmio_error  in  1  bus error, valid the cycle after a granted request

Behaviour:
- Reset (async assert, synchronous release): state = IDLE; mmio_req, mmio_wen, cpu_rsp_valid, cpu_error = 0; mmio_addr, mmio_wdata, cpu_rdata = 0; timeout counter = 0.
- Reset asserted mid-transaction: the transaction is abandoned immediately. No response pulse after release.
- States: IDLE, REQ, RSP.
- cpu_ready = (state == IDLE). A request is accepted on the edge where cpu_req && cpu_ready.
- IDLE, accepted request, legal address:
  - Register wen/addr/wdata into the mmio_* outputs.
  - mmio_req = 1 from the next cycle.
  - Go to REQ.
- Legal address: cpu_addr[2:0] == 0 AND (cpu_addr & ~MMIO_BASE_MASK) == (MMIO_BASE_ADDR & ~MMIO_BASE_MASK).
- IDLE, accepted request, illegal address:
  - No bus activity; stay in IDLE.
  - Next cycle: cpu_rsp_valid = 1, cpu_error = 1, cpu_rdata = 0.
- REQ:
  - mmio_req, mmio_wen, mmio_addr and mmio_wdata are held stable until the grant.
  - On mmio_gnt = 1: mmio_req deasserts next cycle; go to RSP.
  - mmio_gnt = 0: remain in REQ.
- RSP:
  - Sample mmio_rdata and mmio_error into cpu_rdata and cpu_error.
  - Set cpu_rsp_valid = 1 for the next cycle; go to IDLE.
  - For writes, cpu_rdata is the sampled bus value and the core ignores it.
- Latency, request accepted at edge 0 with the grant held high:
  - mmio_req high in cycle 1.
  - RSP in cycle 2.
  - cpu_rsp_valid in cycle 3.
  - Throughput: one access per 3 cycles.
- Simultaneous events:
  - cpu_rsp_valid may be high in the same cycle a new request is accepted. Back-to-back operation is required.
  - cpu_req while not ready is ignored. The core holds the request.
- cpu_rsp_valid is exactly one cycle. cpu_rdata and cpu_error hold their values until the next response.
- Address comparison is full 64-bit. No wrap-around concerns.

Optional Feature:
- Macro: CORE_MMIO_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without a grant.
  - When the count reaches TIMEOUT_CYCLES with mmio_gnt still 0: mmio_req drops next cycle, state returns to IDLE, and cpu_rsp_valid = 1, cpu_error = 1, cpu_rdata = 0 next cycle.
  - A grant in the same cycle the limit is reached wins; the access proceeds normally.
- Undefined: no counter. REQ waits for the grant indefinitely.

Test Plan:
- Read, grant tied 1: read 0x1000 with responder returning 0x0000_0000_0000_0123, error 0 -> mmio_req high exactly one cycle; cpu_rsp_valid at cycle 3; cpu_rdata = 0x123; cpu_error = 0.
- Write, delayed grant: write 0x1008 data 0xDEAD_BEEF with grant asserted 4 cycles late -> mmio_addr and mmio_wdata stable through all 5 REQ cycles; single response pulse with cpu_error = 0.
- Illegal addresses: 0x1004 (misaligned) and 0x4000 (out of region) -> mmio_req never asserts; cpu_rsp_valid next cycle with cpu_error = 1 and cpu_rdata = 0.
- Bus error: read 0x1010 where the responder returns error 1 -> cpu_error = 1 on the response pulse.
- Back-to-back and reset:
  - Two reads issued as soon as cpu_ready allows -> second accepted in the same cycle as the first cpu_rsp_valid.
  - g_resetn pulsed low while in REQ -> all outputs 0 immediately and no response after release.
- Timeout (CORE_MMIO_TIMEOUT_EN, TIMEOUT_CYCLES = 16): grant held 0 -> mmio_req drops after 16 REQ cycles; cpu_error = 1. Without the macro, mmio_req is still high after 100 cycles.
